// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the multi-cycle hazard unit
package hazard_pkg;

  // Forwarding mux selects seen by the Execute-stage ALU operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Mul/div sequencing states
  localparam logic MD_IDLE = 1'b0;
  localparam logic MD_BUSY = 1'b1;

  // Memory-stage result is newer than writeback, so it wins when both match
  function automatic logic [1:0] fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit_p.sv
// rtl/forward_unit_p.sv - EX-stage operand forwarding select
module forward_unit_p
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_write_m,
  input  logic              i_reg_write_w,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);

  logic w_m_valid;
  logic w_w_valid;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value
  assign w_m_valid = i_reg_write_m & (i_rd_m != '0);
  assign w_w_valid = i_reg_write_w & (i_rd_w != '0);

  // Select the youngest in-flight producer for each source operand
  always_comb begin
    o_fwd_a = fwd_pick(w_m_valid & (i_rd_m == i_rs1_e), w_w_valid & (i_rd_w == i_rs1_e));
    o_fwd_b = fwd_pick(w_m_valid & (i_rd_m == i_rs2_e), w_w_valid & (i_rd_w == i_rs2_e));
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard unit with mul/div sequencing and memory wait states
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MdOpE,
  input  logic              MdDone,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MdGo,
  output logic              MdBusy,
  output logic              MdErr,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(MD_TIMEOUT - 1);

  logic          r_state;
  logic [TW-1:0] r_timer;
  logic          r_done_seen;
  logic          r_err;
  logic [CNT_W-1:0] r_cnt;

  logic       w_memwait;
  logic       w_busy;
  logic       w_timeout;
  logic       w_release;
  logic       w_md_hold;
  logic       w_lw;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic       w_flush_d, w_flush_e, w_flush_m, w_flush_w;

  forward_unit_p #(.REG_AW(REG_AW)) u_fwd (
    .i_rs1_e       (Rs1E),
    .i_rs2_e       (Rs2E),
    .i_rd_m        (RdM),
    .i_rd_w        (RdW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_fwd_a       (w_fwd_a),
    .o_fwd_b       (w_fwd_b)
  );

  assign w_memwait = ~MemReadyM;
  assign w_busy    = (r_state == MD_BUSY);
  assign w_timeout = w_busy & (r_timer == TMAX);
  // A completion seen while memory stalled the pipe is remembered in r_done_seen
  assign w_release = r_done_seen | MdDone | w_timeout;
  assign w_md_hold = (~w_busy & MdOpE) | (w_busy & ~w_release);
  assign w_lw      = ResultSrcE0 & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // Stall/flush priority: memory wait, then mul/div hold, then load-use; branch flush last
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    w_flush_w = 1'b0;
    if (!reset) begin
      if (w_memwait) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
      end else begin
        if (w_md_hold) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_flush_m = 1'b1;
        end else if (w_lw) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
        // A branch resolved by an instruction that is being held must not redirect yet
        if (PCSrcE && !w_stall_e) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
    end
  end

  assign StallF    = w_stall_f;
  assign StallD    = w_stall_d;
  assign StallE    = w_stall_e;
  assign StallM    = w_stall_m;
  assign FlushD    = w_flush_d;
  assign FlushE    = w_flush_e;
  assign FlushM    = w_flush_m;
  assign FlushW    = w_flush_w;
  assign ForwardAE = reset ? FWD_RF : w_fwd_a;
  assign ForwardBE = reset ? FWD_RF : w_fwd_b;
  assign MdGo      = ~reset & ~w_busy & MdOpE & ~w_memwait;
  assign MdBusy    = w_busy;
  assign MdErr     = r_err;
  assign StallCnt  = r_cnt;

  // Mul/div sequencer: launch once, count busy cycles, leave only when memory lets E advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= MD_IDLE;
      r_timer     <= '0;
      r_done_seen <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (MdOpE && !w_memwait) begin
            r_state     <= MD_BUSY;
            r_timer     <= '0;
            r_done_seen <= 1'b0;
          end
        end
        default: begin
          // Timer parks at the limit so a timeout during a memory wait stays pending
          if (!w_timeout) r_timer <= r_timer + TW'(1);
          if (w_release && !w_memwait) begin
            r_state     <= MD_IDLE;
            r_done_seen <= 1'b0;
          end else if (MdDone) begin
            r_done_seen <= 1'b1;
          end
        end
      endcase
    end
  end

  // Watchdog abort flag, sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_cnt <= '0;
    else if (w_stall_f && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule
